// File: rtl/pq_multiplier.sv
// Sequential shift-add P*Q multiplier: one multiplier bit per clock, registered product, one-cycle done.
// Optional build macro PQ_MULT_SIGNED_EN: two's complement operands via magnitude multiply and sign fix-up.
module pq_multiplier #(
    parameter int WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dataP,
    input  logic [WIDTH-1:0]     dataQ,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           state
);
    localparam int PW = 2*WIDTH;
    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t            st, st_nxt;
    logic [PW-1:0]     mcand, acc, acc_nxt, result;
    logic [WIDTH-1:0]  mplr, p_op, q_op;
    logic [CW-1:0]     count;
    logic              last;

`ifdef PQ_MULT_SIGNED_EN
    logic neg;

    // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is correct read as unsigned.
    assign p_op   = dataP[WIDTH-1] ? -dataP : dataP;
    assign q_op   = dataQ[WIDTH-1] ? -dataQ : dataQ;
    assign result = neg ? -acc_nxt : acc_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            neg <= 1'b0;
        else if (st == IDLE && start)
            neg <= dataP[WIDTH-1] ^ dataQ[WIDTH-1];
    end
`else
    assign p_op   = dataP;
    assign q_op   = dataQ;
    assign result = acc_nxt;
`endif

    assign acc_nxt = mplr[0] ? acc + mcand : acc;
    assign last    = (st == RUN) && (count == LAST);
    assign busy    = (st != IDLE);
    assign done    = (st == DONE);
    assign state   = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            st <= IDLE;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (start) st_nxt = RUN;
            RUN:     if (last)  st_nxt = DONE;
            DONE:    st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Fixed WIDTH iterations; zero operands still run the full count so latency is constant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (st)
                IDLE: if (start) begin
                    mcand <= {{WIDTH{1'b0}}, p_op};
                    mplr  <= q_op;
                    acc   <= '0;
                    count <= '0;
                end
                RUN: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    count <= count + 1'b1;
                    if (last)
                        product <= result;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/pq_multiplier.md
# pq_multiplier

Sequential shift-add multiplier that sits directly downstream of the operand-capture stage. That stage loads two 7-bit operands, P and Q, into registers under the keypad/confirm control unit. This block samples P and Q on a start pulse, iterates one multiplier bit per clock, and presents a registered product with a one-cycle done pulse. The status outputs feed the display/LED stage.

## Interface
Parameters:
- WIDTH, 7, operand width in bits. The product is 2*WIDTH bits wide.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request to multiply the current dataP/dataQ; sampled only in IDLE
- dataP  in  WIDTH  multiplicand, taken from the P register output
- dataQ  in  WIDTH  multiplier, taken from the Q register output
- busy  out  1  high while in RUN or DONE
- done  out  1  one-cycle pulse; product is valid and newly updated
- product  out  2*WIDTH  registered result; holds until the next completion or reset
- state  out  2  current FSM state, for debug/LEDs

## Operation
- States:
  - IDLE = 2'b00
  - RUN = 2'b01
  - DONE = 2'b10
  - 2'b11 is unreachable; if entered, the next edge goes to IDLE.
- IDLE:
  - If start = 1 at an edge, latch mcand = zero-extended dataP (2*WIDTH bits), mplr = dataQ, acc = 0, count = 0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, on every edge:
  - If mplr[0] = 1, acc <= acc + mcand, truncated mod 2^(2*WIDTH).
  - mcand <= mcand << 1.
  - mplr <= mplr >> 1.
  - count <= count + 1.
- RUN exit: on the edge where count = WIDTH-1 (the WIDTH-th iteration):
  - product <= final accumulator value, including that iteration's add.
  - state <= DONE.
- DONE:
  - done = 1 for exactly this one cycle.
  - The next edge goes to IDLE unconditionally.
- Iteration count is fixed: always exactly WIDTH iterations, with no early exit on zero operands.
- Operands are sampled only on the start edge. Changes to dataP/dataQ during RUN or DONE have no effect.
- start in RUN or DONE is ignored and is not queued. A start held continuously high retriggers on the first IDLE edge after DONE.
- Outputs decoded from state:
  - busy = (state != IDLE)
  - done = (state == DONE)
- Reset (asynchronous, any time, including mid-RUN):
  - state = IDLE; product = 0; done = 0; busy = 0.
  - acc, mcand, mplr and count are cleared.
  - The aborted operation produces no done pulse.

## Timing
- Start is sampled at edge t0.
- RUN occupies the cycles after edges t0 .. t0+WIDTH-1.
- The product register updates at edge t0+WIDTH. done is high during the cycle following that edge.
- Latency from start edge to done: WIDTH cycles (7 at default). Initiation interval: WIDTH+2 cycles (the DONE cycle plus one IDLE edge).
- product changes only at the edge that enters DONE, or on reset.

## Configuration
- Macro: PQ_MULT_SIGNED_EN.
- Defined:
  - dataP and dataQ are WIDTH-bit two's complement.
  - At the start edge, the block latches the magnitudes |P| and |Q| and neg = P[WIDTH-1] ^ Q[WIDTH-1].
  - On the edge entering DONE, product <= neg ? -acc : acc, as 2*WIDTH-bit two's complement.
  - The most-negative operand (-2^(WIDTH-1)) uses its magnitude 2^(WIDTH-1), which fits in WIDTH bits unsigned. (-64)*(-64) = 4096 is representable.
  - Latency is unchanged.
- Undefined: operands and product are unsigned. Maximum result is (2^WIDTH-1)^2 = 16129 at default.

## Test plan
- Reset mid-operation: start with P=5, Q=9; assert reset 3 cycles later → state=0, busy=0, done=0, product=0 immediately. No done pulse follows.
- Basic product: P=5, Q=9, start for one cycle → done high exactly 7 cycles after the start edge, product=45 (14'h002D), busy low one cycle after done.
- Full-scale unsigned (macro undefined): P=127, Q=127 → product=16129 (14'h3F01).
- Ignored restart: start P=3, Q=4; during RUN change to P=10, Q=10 and pulse start → product=12. Exactly one done pulse.
- Zero and latency: P=0, Q=100 → product=0, done still at 7 cycles. Back-to-back with start held high → done pulses spaced 9 cycles apart.
- Signedness:
  - Macro defined: P=7'h7F (-1), Q=3 → product=14'h3FFD (-3).
  - Macro defined: P=7'h40, Q=7'h40 → 14'h1000.
  - Macro undefined: P=7'h7F, Q=3 → 381.
